// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM state encoding, BCD digit
// limits and default timing parameters (125 MHz clock, 10 ms tick).
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS   = 4'd5;

    localparam int unsigned DEF_CLK_DIV    = 1250000;
    localparam int unsigned DEF_DEB_CYCLES = 1250000;

endpackage

// File: rtl/bcd_stopwatch_btn_pulse.sv
// Button conditioner: 2-flop synchronizer, counting debouncer and
// rising-edge detector producing a single-cycle pulse per accepted press.
module btn_pulse
    import bcd_stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level after DEB_CYCLES equal samples; pulse on an accepted rise
    always_ff @(posedge clk) begin
        if (!rst) begin
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt    <= '0;
                stable <= sync2;
                pulse  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh, saturating at 59.99) with debounced
// start/stop and clear buttons. Defining BCD_STOPWATCH_LAP_EN adds a lap
// button that freezes the displayed value while the count keeps running.
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] digit4,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic       running,
    output logic       overflow
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t        state_q;
    state_t        state_d;
    logic          start_p;
    logic          clear_p;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic          at_max;
    logic          overflow_q;
    logic [3:0]    d1_q, d2_q, d3_q, d4_q;

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk(clk), .rst(rst), .btn(btn_start), .pulse(start_p)
    );

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk(clk), .rst(rst), .btn(btn_clear), .pulse(clear_p)
    );

    assign tick   = (state_q == RUN) && (presc_q == PW'(CLK_DIV - 1));
    assign at_max = (d4_q == BCD_MAX_TENS) && (d3_q == BCD_MAX) &&
                    (d2_q == BCD_MAX) && (d1_q == BCD_MAX);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: clear wins; saturation forces PAUSE; overflow blocks resume
    always_comb begin
        state_d = state_q;
        if (clear_p) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_p) state_d = RUN;
                RUN:     if (start_p || (tick && at_max)) state_d = PAUSE;
                PAUSE:   if (start_p && !overflow_q) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        running = (state_q == RUN);
    end

    // Prescaler: counts in RUN, holds in PAUSE, zero in IDLE
    always_ff @(posedge clk) begin
        if (!rst || clear_p || state_q == IDLE) begin
            presc_q <= '0;
        end else if (state_q == RUN) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // BCD counter with ripple carry; saturates at 59.99 and sets overflow
    always_ff @(posedge clk) begin
        if (!rst || clear_p) begin
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
            d4_q       <= '0;
            overflow_q <= 1'b0;
        end else if (tick) begin
            if (at_max) begin
                overflow_q <= 1'b1;
            end else if (d1_q != BCD_MAX) begin
                d1_q <= d1_q + 4'd1;
            end else begin
                d1_q <= '0;
                if (d2_q != BCD_MAX) begin
                    d2_q <= d2_q + 4'd1;
                end else begin
                    d2_q <= '0;
                    if (d3_q != BCD_MAX) begin
                        d3_q <= d3_q + 4'd1;
                    end else begin
                        d3_q <= '0;
                        d4_q <= (d4_q == BCD_MAX_TENS) ? 4'd0 : d4_q + 4'd1;
                    end
                end
            end
        end
    end

    assign overflow = overflow_q;

`ifdef BCD_STOPWATCH_LAP_EN
    logic       lap_p;
    logic       lap_q;
    logic [3:0] l1_q, l2_q, l3_q, l4_q;

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clk(clk), .rst(rst), .btn(btn_lap), .pulse(lap_p)
    );

    // Lap latch: toggled by lap pulses in RUN, dropped when RUN is left or cleared
    always_ff @(posedge clk) begin
        if (!rst || clear_p || state_q != RUN) begin
            lap_q <= 1'b0;
            l1_q  <= '0;
            l2_q  <= '0;
            l3_q  <= '0;
            l4_q  <= '0;
        end else if (lap_p) begin
            lap_q <= !lap_q;
            l1_q  <= d1_q;
            l2_q  <= d2_q;
            l3_q  <= d3_q;
            l4_q  <= d4_q;
        end
    end

    // Display mux: frozen lap value or live count
    always_comb begin
        digit1 = lap_q ? l1_q : d1_q;
        digit2 = lap_q ? l2_q : d2_q;
        digit3 = lap_q ? l3_q : d3_q;
        digit4 = lap_q ? l4_q : d4_q;
    end
`else
    logic lap_unused;
    assign lap_unused = btn_lap;

    // Display always shows the live count
    always_comb begin
        digit1 = d1_q;
        digit2 = d2_q;
        digit3 = d3_q;
        digit4 = d4_q;
    end
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch (CLK_DIV=4, DEB_CYCLES=3).
// Reference model: elapsed hundredths = cycles spent running / CLK_DIV,
// saturating at 5999 with overflow once the 6000th tick arrives.
module tb_bcd_stopwatch;

    localparam int DIV = 4;
    localparam int SAT = 6000 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic [3:0] digit4, digit3, digit2, digit1;
    logic       running, overflow;
    logic [15:0] dig;

    int errors = 0;
    int checks = 0;
    int run_cycles = 0;
    bit mon_en = 1'b0;
    bit skip_digits = 1'b0;

    typedef struct {
        int ticks;
        int bcd;
    } vec_t;
    localparam int NTBL = 8;
    vec_t tbl[NTBL];
    bit   tbl_done[NTBL];

    bcd_stopwatch #(.CLK_DIV(DIV), .DEB_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_lap(btn_lap), .digit4(digit4), .digit3(digit3), .digit2(digit2),
        .digit1(digit1), .running(running), .overflow(overflow)
    );

    assign dig = {digit4, digit3, digit2, digit1};

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_bcd(input int t);
        int h;
        h = (t > 5999) ? 5999 : t;
        return ((h / 1000) << 12) | (((h / 100) % 10) << 8) |
               (((h / 10) % 10) << 4) | (h % 10);
    endfunction

    // Continuous model comparison on the falling edge
    always @(negedge clk) begin
        int t;
        t = run_cycles / DIV;
        if (mon_en) begin
            if (!skip_digits) chk("live_digits", int'(dig), exp_bcd(t));
            chk("overflow_flag", int'(overflow), int'(t >= 6000));
            if (t >= 6000) chk("sat_running", int'(running), 0);
            for (int i = 0; i < NTBL; i++) begin
                if (!tbl_done[i] && !skip_digits && tbl[i].ticks == t) begin
                    tbl_done[i] = 1'b1;
                    chk($sformatf("table_%0d", tbl[i].ticks), int'(dig), tbl[i].bcd);
                end
            end
        end
        if (running === 1'b1) run_cycles++;
    end

    task automatic press(input bit s, input bit c, input bit l);
        @(posedge clk); #1;
        btn_start = s; btn_clear = c; btn_lap = l;
        repeat (8) @(posedge clk);
        #1;
        btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_running(input bit exp, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (running !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(running), int'(exp));
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n = 0;
        while (run_cycles < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(run_cycles >= target), 1);
    endtask

    task automatic do_clear(input bit with_start, input string name);
        mon_en = 1'b0;
        press(with_start, 1'b1, 1'b0);
        @(negedge clk);
        chk({name, "_digits"}, int'(dig), 0);
        chk({name, "_overflow"}, int'(overflow), 0);
        chk({name, "_running"}, int'(running), 0);
        repeat (10) @(negedge clk);
        chk({name, "_stay_idle"}, int'(running), 0);
        run_cycles = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        logic [15:0] frozen;
        int          c0;

        tbl[0] = '{ticks: 1,    bcd: 'h0001};
        tbl[1] = '{ticks: 10,   bcd: 'h0010};
        tbl[2] = '{ticks: 59,   bcd: 'h0059};
        tbl[3] = '{ticks: 100,  bcd: 'h0100};
        tbl[4] = '{ticks: 610,  bcd: 'h0610};
        tbl[5] = '{ticks: 999,  bcd: 'h0999};
        tbl[6] = '{ticks: 1000, bcd: 'h1000};
        tbl[7] = '{ticks: 5999, bcd: 'h5999};

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_digits", int'(dig), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_cycles = 0;
        mon_en = 1'b1;

        // Two-cycle glitch is shorter than the debounce window
        @(posedge clk); #1;
        btn_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_start = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch_ignored", int'(running), 0);

        // Bounce then hold: exactly one start pulse
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            btn_start = ~btn_start;
        end
        @(posedge clk); #1;
        btn_start = 1'b1;
        wait_running(1'b1, 30, "bounce_start");
        repeat (10) @(negedge clk);
        chk("bounce_single_pulse", int'(running), 1);
        @(posedge clk); #1;
        btn_start = 1'b0;

        // Carry chain through 10.00
        run_until(1001 * DIV, 6000, "reach_10s");

        // Random pause/resume at varied prescaler phases
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 7)) @(posedge clk);
            press(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk("pause_running", int'(running), 0);
            repeat ($urandom_range(3, 40)) @(negedge clk);
            press(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk("resume_running", int'(running), 1);
            repeat ($urandom_range(5, 60)) @(negedge clk);
        end

`ifdef BCD_STOPWATCH_LAP_EN
        skip_digits = 1'b1;
        press(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        frozen = dig;
        c0 = run_cycles;
        repeat (40) @(negedge clk);
        chk("lap_frozen", int'(dig), int'(frozen));
        chk("lap_count_advances", int'(run_cycles >= c0 + 40), 1);
        press(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        skip_digits = 1'b0;
`else
        c0 = run_cycles;
        press(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("lap_no_effect", int'(running), 1);
        frozen = dig;
        chk("lap_live_after", int'(frozen), exp_bcd(run_cycles / DIV));
        chk("lap_count_advances", int'(run_cycles > c0), 1);
`endif

        // Saturation at 59.99
        run_until(SAT, SAT + 1000, "reach_saturation");
        wait_running(1'b0, 10, "sat_stops");
        chk("sat_digits", int'(dig), 'h5999);
        chk("sat_overflow", int'(overflow), 1);
        press(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("sat_start_ignored", int'(running), 0);
        chk("sat_digits_hold", int'(dig), 'h5999);
        do_clear(1'b0, "clear_after_sat");

        // Clear beats start when both pulse together
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("restart_running", int'(running), 1);
        repeat (37) @(negedge clk);
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("prio_paused", int'(running), 0);
        do_clear(1'b1, "clear_prio");

        // Reset mid-count discards progress
        press(1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_cycles = 0;
        @(negedge clk);
        chk("midreset_digits", int'(dig), 0);
        chk("midreset_running", int'(running), 0);
        repeat (20) @(negedge clk);
        chk("midreset_no_pulse", int'(running), 0);
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < NTBL; i++)
            chk($sformatf("table_seen_%0d", tbl[i].ticks), int'(tbl_done[i]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter CLK_DIV, default 1250000: clk cycles per 10 ms hundredths tick (125 MHz clk).
REQ-002 Parameter DEB_CYCLES, default 1250000: cycles a raw button must stay stable before it is accepted.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 btn_start  input  1  raw start/stop button, asynchronous to clk.
REQ-006 btn_clear  input  1  raw clear button, asynchronous to clk.
REQ-007 btn_lap  input  1  raw lap button, asynchronous to clk; ignored unless LAP_EN is defined.
REQ-008 digit4, digit3, digit2, digit1  output  4 each  BCD tens-of-seconds, seconds, tenths, hundredths; they feed the 4-digit display stage directly.
REQ-009 running  output  1  high while in state RUN.
REQ-010 overflow  output  1  sticky flag; high once the count saturates at 59.99.

Function
REQ-011 Each raw button passes through a 2-flop synchronizer, then a debouncer, then a rising-edge detector that yields a one-cycle pulse.
REQ-012 Debounce: a new level is accepted only after DEB_CYCLES consecutive equal synchronized samples; any change restarts the count.
REQ-013 FSM states: IDLE, RUN, PAUSE.
REQ-014 FSM transitions: IDLE -start-> RUN; RUN -start-> PAUSE; PAUSE -start-> RUN; any state -clear-> IDLE.
REQ-015 Prescaler counts 0..CLK_DIV-1 only in RUN and emits tick on the terminal count; it holds in PAUSE and zeroes in IDLE.
REQ-016 On tick, the 4-digit BCD counter increments in the cycle after tick, with digit1/digit2/digit3 wrapping 9->0 and carrying, and digit4 wrapping 5->0 with carry.
REQ-017 At 59.99 a tick does not wrap: the counter holds 5,9,9,9, overflow sets, and the FSM enters PAUSE in the same edge.
REQ-018 In PAUSE with overflow set, a start pulse is ignored; only clear leaves the state.
REQ-019 Clear pulse: zero all digits, prescaler and overflow, and go to IDLE on the next edge.
REQ-020 Clear has priority over start and lap when pulses arrive in the same cycle.
REQ-021 Digits never hold a non-BCD code (>9, or >5 on digit4).
REQ-022 The prescaler restarts from 0 after IDLE but resumes from its held value after PAUSE, so no partial tick is lost.

Reset
REQ-023 While rst=0 at a clk edge: FSM IDLE, all digits 0, prescaler 0, overflow 0, running 0, debouncer counters 0, stable button levels 0, lap latch cleared.
REQ-024 Reset mid-count discards all progress; no button pulse is generated by the reset release itself.

Configuration
REQ-025 Macro BCD_STOPWATCH_LAP_EN.
REQ-026 With the macro defined, a lap pulse in RUN freezes the outputs at the current count while the internal count continues; a second lap pulse, or leaving RUN, releases the outputs to live.
REQ-027 With the macro defined, a lap pulse outside RUN is ignored.
REQ-028 With the macro undefined, btn_lap is unused, no lap register is built, and the outputs always show the live count.

Structure
REQ-029 Shared package holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2), the BCD limit constants 9 and 5, and the default CLK_DIV and DEB_CYCLES values.
REQ-030 One sub-module, btn_pulse (synchronizer + debouncer + edge detect, parameter DEB_CYCLES), is instantiated three times.

Verification (CLK_DIV=4, DEB_CYCLES=3)
REQ-031 Reset: hold rst=0 for 2 cycles -> digits 0,0,0,0, running=0, overflow=0.
REQ-032 Bounce: toggle btn_start each cycle for 10 cycles, then hold it high -> exactly one start pulse, running=1.
REQ-033 Carry chain: run for 100 ticks -> digits 0,1,0,0; run to 9.99 plus 1 tick -> 1,0,0,0.
REQ-034 Saturation: run 6000 ticks -> 5,9,9,9, overflow=1, running=0; a further start is ignored; clear -> 0,0,0,0, overflow=0.
REQ-035 Priority and pause: clear and start pulses in the same cycle -> IDLE; pause at prescaler=2 and resume -> next tick occurs 2 cycles later.
REQ-036 LAP_EN build: lap pulse at 0.25 -> outputs frozen at 0,0,2,5 while internal count advances; second lap -> outputs show the live count.
